// File: rtl/iiitb_fifo_wr_arbiter.sv
// Two-producer write-port arbiter in front of the FIFO write side.
// Round-robin ownership with a bounded burst per grant. sig_Full gates
// every write, so the FIFO never sees a write while it is full.
//
// Handshake: a producer holds req_n/data_n until it samples ack_n=1 at a
// rising edge, and may drop req_n at any time without an ack. ack_n is
// combinational and equals write_Enable while producer n owns the port.
module iiitb_fifo_wr_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int BURST_LEN   = 4,
   parameter int COUNT_WIDTH = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_0,
   input  logic [DATA_WIDTH-1:0] data_0,
   output logic                  ack_0,
   input  logic                  req_1,
   input  logic [DATA_WIDTH-1:0] data_1,
   output logic                  ack_1,
   input  logic                  sig_Full,
   output logic                  write_Enable,
   output logic [DATA_WIDTH-1:0] buffer_Input,
   output logic                  grant_0,
   output logic                  grant_1
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   // Beat index of the final beat of a burst; release happens on its ack,
   // so the counter never wraps.
   localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BURST_LEN - 1);

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
   logic                   last_served_q, last_served_d;
   logic                   wr_fire;

   // State, beat counter and last owner; reset leaves producer 0 with the
   // first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         beat_count_q  <= '0;
         last_served_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         beat_count_q  <= beat_count_d;
         last_served_q <= last_served_d;
      end
   end

   // Next-state, burst counting and the combinational write path.
   always_comb begin
      state_d       = state_q;
      beat_count_d  = beat_count_q;
      last_served_d = last_served_q;
      wr_fire       = 1'b0;
      write_Enable  = 1'b0;
      ack_0         = 1'b0;
      ack_1         = 1'b0;
      buffer_Input  = '0;

      case (state_q)
         IDLE: begin
            if (req_0 && req_1) begin
               state_d      = last_served_q ? BUSY0 : BUSY1;
               beat_count_d = '0;
            end else if (req_0) begin
               state_d      = BUSY0;
               beat_count_d = '0;
            end else if (req_1) begin
               state_d      = BUSY1;
               beat_count_d = '0;
            end
         end

         BUSY0: begin
            wr_fire      = req_0 & ~sig_Full;
            write_Enable = wr_fire;
            ack_0        = wr_fire;
            buffer_Input = data_0;
            // A full stall (req_0 with sig_Full) neither counts nor releases.
            if (!req_0 || (wr_fire && (beat_count_q == LAST_BEAT))) begin
               last_served_d = 1'b0;
               beat_count_d  = '0;
               state_d       = req_1 ? BUSY1 : IDLE;
            end else if (wr_fire) begin
               beat_count_d = beat_count_q + COUNT_WIDTH'(1);
            end
         end

         BUSY1: begin
            wr_fire      = req_1 & ~sig_Full;
            write_Enable = wr_fire;
            ack_1        = wr_fire;
            buffer_Input = data_1;
            if (!req_1 || (wr_fire && (beat_count_q == LAST_BEAT))) begin
               last_served_d = 1'b1;
               beat_count_d  = '0;
               state_d       = req_0 ? BUSY0 : IDLE;
            end else if (wr_fire) begin
               beat_count_d = beat_count_q + COUNT_WIDTH'(1);
            end
         end

         default: begin
            state_d      = IDLE;
            beat_count_d = '0;
         end
      endcase
   end

   // Grants decode the registered owner state, so they drop with reset.
   assign grant_0 = (state_q == BUSY0);
   assign grant_1 = (state_q == BUSY1);

endmodule

// File: tb/tb_iiitb_fifo_wr_arbiter.sv
// Directed bench for the FIFO write-port arbiter. Two producer models feed
// word queues; every expected FIFO write {producer id, data} is queued when
// the words are loaded and popped as the DUT writes.
module tb_iiitb_fifo_wr_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_0 = 1'b0;
   logic [7:0] data_0 = 8'h00;
   logic       ack_0;
   logic       req_1 = 1'b0;
   logic [7:0] data_1 = 8'h00;
   logic       ack_1;
   logic       sig_Full = 1'b0;
   logic       write_Enable;
   logic [7:0] buffer_Input;
   logic       grant_0;
   logic       grant_1;

   iiitb_fifo_wr_arbiter #(
      .DATA_WIDTH (8),
      .BURST_LEN  (4),
      .COUNT_WIDTH(2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_0       (req_0),
      .data_0      (data_0),
      .ack_0       (ack_0),
      .req_1       (req_1),
      .data_1      (data_1),
      .ack_1       (ack_1),
      .sig_Full    (sig_Full),
      .write_Enable(write_Enable),
      .buffer_Input(buffer_Input),
      .grant_0     (grant_0),
      .grant_1     (grant_1)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- bench state ----------------
   int         total = 0;
   int         bad   = 0;
   logic [8:0] exp_q[$];
   logic [7:0] src0_q[$];
   logic [7:0] src1_q[$];
   logic       en1 = 1'b1;
   logic       g0_s, g1_s, we_s, a0_s, a1_s;
   logic [7:0] bi_s;
   logic       ack1_seen = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_inputs();
      req_0  = (src0_q.size() > 0);
      data_0 = req_0 ? src0_q[0] : 8'h00;
      req_1  = en1 && (src1_q.size() > 0);
      data_1 = req_1 ? src1_q[0] : 8'h00;
   endtask

   task automatic load(input int id, input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         if (id == 0) src0_q.push_back(first + 8'(i));
         else         src1_q.push_back(first + 8'(i));
      end
   endtask

   task automatic expect_words(input logic id, input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({id, first + 8'(i)});
   endtask

   // One clock cycle: observe outputs at the falling edge, score any write,
   // then let producers advance on the acks they saw at the rising edge.
   task automatic cycle();
      @(negedge clock);
      g0_s = grant_0;
      g1_s = grant_1;
      we_s = write_Enable;
      a0_s = ack_0;
      a1_s = ack_1;
      bi_s = buffer_Input;
      if (a1_s) ack1_seen = 1'b1;
      chk("ack_vs_we", 32'(a0_s | a1_s), 32'(we_s));
      chk("one_grant", 32'(g0_s & g1_s), 32'd0);
      if (sig_Full) chk("no_write_when_full", 32'(we_s), 32'd0);
      if (we_s) begin
         chk("sb_underflow", 32'(exp_q.size() == 0), 32'd0);
         if (exp_q.size() > 0) chk("sb_write", 32'({a1_s, bi_s}), 32'(exp_q.pop_front()));
      end
      @(posedge clock);
      #1;
      if (a0_s && src0_q.size() > 0) void'(src0_q.pop_front());
      if (a1_s && src1_q.size() > 0) void'(src1_q.pop_front());
      drive_inputs();
   endtask

   task automatic run_drain(input int budget, input string tag);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      chk("rst_we", 32'(write_Enable), 32'd0);
      chk("rst_ack0", 32'(ack_0), 32'd0);
      chk("rst_ack1", 32'(ack_1), 32'd0);
      chk("rst_grant0", 32'(grant_0), 32'd0);
      chk("rst_grant1", 32'(grant_1), 32'd0);
      chk("rst_data", 32'(buffer_Input), 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();

      // Single producer: 6 words -> 4-beat burst, one IDLE cycle, 2 beats.
      ack1_seen = 1'b0;
      load(0, 8'h11, 6);
      expect_words(1'b0, 8'h11, 6);
      drive_inputs();
      cycle();
      chk("sp_arb_grant0", 32'(g0_s), 32'd0);
      chk("sp_arb_we", 32'(we_s), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sp_burst_grant0", 32'(g0_s), 32'd1);
         chk("sp_burst_we", 32'(we_s), 32'd1);
      end
      cycle();
      chk("sp_gap_we", 32'(we_s), 32'd0);
      chk("sp_gap_grant0", 32'(g0_s), 32'd0);
      chk("sp_gap_data", 32'(bi_s), 32'd0);
      cycle();
      chk("sp_tail_we", 32'(we_s), 32'd1);
      cycle();
      chk("sp_tail_we", 32'(we_s), 32'd1);
      cycle();
      chk("sp_withdraw_we", 32'(we_s), 32'd0);
      chk("sp_withdraw_grant0", 32'(g0_s), 32'd1);
      cycle();
      chk("sp_drain", 32'(exp_q.size()), 32'd0);
      chk("sp_no_ack1", 32'(ack1_seen), 32'd0);

      // Contention from reset: alternating 4-beat bursts, no bubbles.
      do_reset();
      load(0, 8'h20, 8);
      load(1, 8'h30, 8);
      expect_words(1'b0, 8'h20, 4);
      expect_words(1'b1, 8'h30, 4);
      expect_words(1'b0, 8'h24, 4);
      expect_words(1'b1, 8'h34, 4);
      drive_inputs();
      cycle();
      chk("ct_arb_we", 32'(we_s), 32'd0);
      for (int i = 0; i < 16; i++) begin
         cycle();
         chk("ct_no_bubble", 32'(we_s), 32'd1);
      end
      cycle();
      chk("ct_drain", 32'(exp_q.size()), 32'd0);

      // Full stall on the third beat of producer 1's burst.
      load(1, 8'h40, 5);
      expect_words(1'b1, 8'h40, 5);
      drive_inputs();
      cycle();
      cycle();
      cycle();
      sig_Full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("fs_stall_we", 32'(we_s), 32'd0);
         chk("fs_stall_ack1", 32'(a1_s), 32'd0);
         chk("fs_stall_grant1", 32'(g1_s), 32'd1);
      end
      sig_Full = 1'b0;
      cycle();
      chk("fs_beat3_we", 32'(we_s), 32'd1);
      cycle();
      chk("fs_beat4_we", 32'(we_s), 32'd1);
      cycle();
      chk("fs_release_we", 32'(we_s), 32'd0);
      chk("fs_release_grant1", 32'(g1_s), 32'd0);
      cycle();
      chk("fs_next_burst_we", 32'(we_s), 32'd1);
      repeat (2) cycle();
      chk("fs_drain", 32'(exp_q.size()), 32'd0);

      // Early withdrawal of producer 1 while producer 0 waits.
      load(1, 8'h50, 4);
      expect_words(1'b1, 8'h50, 2);
      expect_words(1'b0, 8'h58, 2);
      expect_words(1'b1, 8'h52, 2);
      drive_inputs();
      cycle();
      load(0, 8'h58, 2);
      drive_inputs();
      cycle();
      cycle();
      en1 = 1'b0;
      drive_inputs();
      cycle();
      chk("wd_drop_we", 32'(we_s), 32'd0);
      chk("wd_drop_grant1", 32'(g1_s), 32'd1);
      cycle();
      chk("wd_handoff_grant0", 32'(g0_s), 32'd1);
      chk("wd_handoff_we", 32'(we_s), 32'd1);
      en1 = 1'b1;
      drive_inputs();
      run_drain(20, "wd_drain");
      repeat (2) cycle();

      // Asynchronous reset during the third beat of a producer 0 burst.
      load(0, 8'h60, 6);
      expect_words(1'b0, 8'h60, 6);
      expect_words(1'b1, 8'h70, 4);
      drive_inputs();
      cycle();
      cycle();
      cycle();
      #2;
      reset = 1'b1;
      #1;
      chk("ar_we", 32'(write_Enable), 32'd0);
      chk("ar_ack0", 32'(ack_0), 32'd0);
      chk("ar_grant0", 32'(grant_0), 32'd0);
      chk("ar_grant1", 32'(grant_1), 32'd0);
      @(posedge clock);
      #1;
      chk("ar_held_we", 32'(write_Enable), 32'd0);
      load(1, 8'h70, 4);
      drive_inputs();
      reset = 1'b0;
      cycle();
      chk("ar_arb_we", 32'(we_s), 32'd0);
      cycle();
      chk("ar_tie_grant0", 32'(g0_s), 32'd1);
      chk("ar_tie_grant1", 32'(g1_s), 32'd0);
      run_drain(30, "ar_drain");
      repeat (2) cycle();

      // sig_Full toggling every cycle under contention.
      load(0, 8'h80, 8);
      load(1, 8'h90, 8);
      expect_words(1'b0, 8'h80, 4);
      expect_words(1'b1, 8'h90, 4);
      expect_words(1'b0, 8'h84, 4);
      expect_words(1'b1, 8'h94, 4);
      drive_inputs();
      for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
         sig_Full = ~sig_Full;
         cycle();
      end
      sig_Full = 1'b0;
      chk("tg_drain", 32'(exp_q.size()), 32'd0);
      repeat (2) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
